// File: rtl/adiabatic_pkg.sv
// rtl/adiabatic_pkg.sv - shared types and constants for the adiabatic register driver
//
// Purpose: sequencer state encoding, complementary rail-pair type and sizing
// constants used by the write sequencer and its rail drivers.
package adiabatic_pkg;

  localparam int REG_WIDTH = 16;
  localparam int PHASE_MAX = 15;
  // Wide enough to hold any legal phase length minus one.
  localparam int PHASE_CNT_W = $clog2(PHASE_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CAPTURE,
    CHECK,
    RECOVER
  } state_e;

  typedef struct packed {
    logic pos;
    logic neg;
  } rail_pair_t;

endpackage

// File: rtl/rail_pair_drv.sv
// rtl/rail_pair_drv.sv - registered complementary rail pair
//
// Purpose: one registered pos/neg rail; neg is always the inverse of pos,
// including while reset is asserted (pos=0, neg=1).
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low reset
//   pos_d_i  next value of the pos rail
//   rail_o   registered {pos, neg} pair
module rail_pair_drv
  import adiabatic_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pos_d_i,
  output rail_pair_t rail_o
);

  rail_pair_t rail_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rail_q <= '{pos: 1'b0, neg: 1'b1};
    end else begin
      rail_q <= '{pos: pos_d_i, neg: ~pos_d_i};
    end
  end

  assign rail_o = rail_q;

endmodule

// File: rtl/reg16_write_sequencer.sv
// rtl/reg16_write_sequencer.sv - four-phase write/readback sequencer for the adiabatic register
//
// Purpose: accepts a write over valid/ready, drives the register data bus,
// steps the T / pclk / F rail pairs through setup, capture, check and recover
// phases, reads the register back and reports completion and mismatches.
// Ports:
//   clkpos, rstn                 clock and asynchronous active-low reset
//   wr_valid, wr_ready, wr_data  write request handshake
//   reg_in, reg_out              register data input (driven) and readback
//   T/p/F clkpos/clkneg          registered complementary rail pairs
//   done, mismatch               one-cycle completion / readback-error pulses
//   err_cnt                      saturating mismatch count
//   shadow                       last accepted word
module reg16_write_sequencer
  import adiabatic_pkg::*;
#(
  parameter int WIDTH        = REG_WIDTH,
  parameter int PHASE_CYCLES = 2,
  parameter int ERR_W        = 8
) (
  input  logic             clkpos,
  input  logic             rstn,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] reg_in,
  input  logic [WIDTH-1:0] reg_out,
  output logic             Tclkpos,
  output logic             Tclkneg,
  output logic             pclkpos,
  output logic             pclkneg,
  output logic             Fclkpos,
  output logic             Fclkneg,
  output logic             done,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] shadow
);

  localparam logic [PHASE_CNT_W-1:0] CNT_LOAD = PHASE_CNT_W'(PHASE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [PHASE_CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]        data_q;
  logic [WIDTH-1:0]        shadow_q;
  logic                    fail_q;
  logic                    done_q;
  logic                    mismatch_q;
  logic [ERR_W-1:0]        err_q;
  logic                    ready_q;

  logic accept;
  logic last_phase;
  logic done_d;
  logic t_d, p_d, f_d;

  rail_pair_t t_rail, p_rail, f_rail;

  assign accept     = wr_valid & ready_q;
  assign last_phase = (cnt_q == '0);

  // State register
  always_ff @(posedge clkpos or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the phase counter reloads on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          cnt_d   = CNT_LOAD;
        end
      end
      default: begin
        if (last_phase) begin
          cnt_d = CNT_LOAD;
          case (state_q)
            SETUP:   state_d = CAPTURE;
            CAPTURE: state_d = CHECK;
            CHECK:   state_d = RECOVER;
            default: state_d = IDLE;
          endcase
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  // Output logic. Rails are decoded from the next state so that the
  // registered rail tracks the state it belongs to in the same cycle.
  always_comb begin
    t_d    = (state_d == SETUP) || (state_d == CAPTURE);
    p_d    = (state_d == CAPTURE) || (state_d == CHECK);
    f_d    = (state_d == RECOVER);
    done_d = (state_q == RECOVER) && last_phase;
  end

  // Datapath, readback compare and status
  always_ff @(posedge clkpos or negedge rstn) begin
    if (!rstn) begin
      data_q     <= '0;
      shadow_q   <= '0;
      fail_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      if (accept) begin
        data_q   <= wr_data;
        shadow_q <= wr_data;
      end
      // Readback is taken at the end of the last CHECK cycle, while pclk is
      // still powering the register.
      if ((state_q == CHECK) && last_phase) begin
        fail_q <= (reg_out != data_q);
      end
      done_q     <= done_d;
      mismatch_q <= done_d & fail_q;
      if (done_d && fail_q && (err_q != '1)) begin
        err_q <= err_q + 1'b1;
      end
      ready_q <= (state_d == IDLE);
    end
  end

  rail_pair_drv u_t_rail (.clk_i(clkpos), .rst_ni(rstn), .pos_d_i(t_d), .rail_o(t_rail));
  rail_pair_drv u_p_rail (.clk_i(clkpos), .rst_ni(rstn), .pos_d_i(p_d), .rail_o(p_rail));
  rail_pair_drv u_f_rail (.clk_i(clkpos), .rst_ni(rstn), .pos_d_i(f_d), .rail_o(f_rail));

  assign Tclkpos  = t_rail.pos;
  assign Tclkneg  = t_rail.neg;
  assign pclkpos  = p_rail.pos;
  assign pclkneg  = p_rail.neg;
  assign Fclkpos  = f_rail.pos;
  assign Fclkneg  = f_rail.neg;
  assign wr_ready = ready_q;
  assign reg_in   = data_q;
  assign shadow   = shadow_q;
  assign done     = done_q;
  assign mismatch = mismatch_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_reg16_write_sequencer.sv
// tb/tb_reg16_write_sequencer.sv - scoreboard bench for reg16_write_sequencer
module tb_reg16_write_sequencer;

  typedef struct {
    logic        mism;
    logic [15:0] shadow;
    logic [7:0]  err;
  } exp_t;

  logic        clkpos = 1'b0;
  logic        rstn;
  int          n_total = 0;
  int          n_pass  = 0;

  // Default instance: PHASE_CYCLES=2, ERR_W=8
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data, reg_in, reg_out, shadow, flip;
  logic        Tclkpos, Tclkneg, pclkpos, pclkneg, Fclkpos, Fclkneg;
  logic        done, mismatch;
  logic [7:0]  err_cnt;
  exp_t        sb[$];

  // Second instance: PHASE_CYCLES=1, ERR_W=2
  logic        wr_valid2, wr_ready2;
  logic [15:0] wr_data2, reg_in2, reg_out2, shadow2, flip2;
  logic        Tpos2, Tneg2, ppos2, pneg2, Fpos2, Fneg2;
  logic        done2, mismatch2;
  logic [1:0]  err_cnt2;
  exp_t        sb2[$];

  logic [2:0]  pos3, neg3, inv3;
  exp_t        e1, e2;

  always #5 clkpos = ~clkpos;

  // Register models: loopback with an optional bit-flip to force mismatches.
  assign reg_out  = reg_in ^ flip;
  assign reg_out2 = reg_in2 ^ flip2;

  reg16_write_sequencer dut (
    .clkpos(clkpos), .rstn(rstn), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .reg_in(reg_in), .reg_out(reg_out),
    .Tclkpos(Tclkpos), .Tclkneg(Tclkneg), .pclkpos(pclkpos), .pclkneg(pclkneg),
    .Fclkpos(Fclkpos), .Fclkneg(Fclkneg), .done(done), .mismatch(mismatch),
    .err_cnt(err_cnt), .shadow(shadow)
  );

  reg16_write_sequencer #(.WIDTH(16), .PHASE_CYCLES(1), .ERR_W(2)) dut2 (
    .clkpos(clkpos), .rstn(rstn), .wr_valid(wr_valid2), .wr_ready(wr_ready2),
    .wr_data(wr_data2), .reg_in(reg_in2), .reg_out(reg_out2),
    .Tclkpos(Tpos2), .Tclkneg(Tneg2), .pclkpos(ppos2), .pclkneg(pneg2),
    .Fclkpos(Fpos2), .Fclkneg(Fneg2), .done(done2), .mismatch(mismatch2),
    .err_cnt(err_cnt2), .shadow(shadow2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic accept(input logic [15:0] d, input logic [15:0] fl,
                        input logic em, input logic [7:0] ee);
    exp_t e;
    chk("ready_before_accept", wr_ready, 1);
    flip     = fl;
    wr_data  = d;
    wr_valid = 1'b1;
    e.mism = em; e.shadow = d; e.err = ee;
    sb.push_back(e);
    @(posedge clkpos); #1;
    wr_valid = 1'b0;
  endtask

  task automatic accept2(input logic [15:0] d, input logic [15:0] fl,
                         input logic em, input logic [7:0] ee);
    exp_t e;
    chk("ready2_before_accept", wr_ready2, 1);
    flip2     = fl;
    wr_data2  = d;
    wr_valid2 = 1'b1;
    e.mism = em; e.shadow = d; e.err = ee;
    sb2.push_back(e);
    @(posedge clkpos); #1;
    wr_valid2 = 1'b0;
  endtask

  // Monitor for the default instance: rail invariant every cycle, scoreboard on done.
  always @(negedge clkpos) begin
    pos3 = {Tclkpos, pclkpos, Fclkpos};
    neg3 = {Tclkneg, pclkneg, Fclkneg};
    inv3 = ~pos3;
    chk("rail_invariant", neg3, inv3);
    if (done) begin
      chk("sb_nonempty_at_done", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e1 = sb.pop_front();
        chk("done_mismatch", mismatch, e1.mism);
        chk("done_shadow", shadow, e1.shadow);
        chk("done_err_cnt", err_cnt, e1.err);
      end
    end else begin
      chk("mismatch_without_done", mismatch, 0);
    end
  end

  // Monitor for the short-phase, narrow-counter instance.
  always @(negedge clkpos) begin
    if (done2) begin
      chk("sb2_nonempty_at_done", sb2.size() > 0, 1);
      if (sb2.size() > 0) begin
        e2 = sb2.pop_front();
        chk("done2_mismatch", mismatch2, e2.mism);
        chk("done2_shadow", shadow2, e2.shadow);
        chk("done2_err_cnt", {6'd0, err_cnt2}, e2.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running, expected finished");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    wr_valid = 1'b0; wr_data = '0; flip = '0;
    wr_valid2 = 1'b0; wr_data2 = '0; flip2 = '0;

    // Reset then idle
    repeat (3) @(posedge clkpos);
    @(negedge clkpos);
    chk("rst_pos_rails", {Tclkpos, pclkpos, Fclkpos}, 3'b000);
    chk("rst_neg_rails", {Tclkneg, pclkneg, Fclkneg}, 3'b111);
    chk("rst_done", {done, mismatch}, 2'b00);
    @(posedge clkpos); #1;
    rstn = 1'b1;
    @(posedge clkpos); #1;
    chk("idle_ready", wr_ready, 1);
    chk("idle_err_cnt", err_cnt, 0);
    chk("idle_shadow", shadow, 0);
    chk("idle_reg_in", reg_in, 0);
    chk("idle_rails", {Tclkpos, pclkpos, Fclkpos, Tclkneg, pclkneg, Fclkneg}, 6'b000111);

    // Single correct write with full rail timing trace
    accept(16'hA5C3, 16'h0000, 1'b0, 8'd0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clkpos);
      chk($sformatf("w1_T_c%0d", c), Tclkpos, (c >= 1 && c <= 4));
      chk($sformatf("w1_p_c%0d", c), pclkpos, (c >= 3 && c <= 6));
      chk($sformatf("w1_F_c%0d", c), Fclkpos, (c >= 7 && c <= 8));
      chk($sformatf("w1_ready_c%0d", c), wr_ready, (c == 9));
      chk($sformatf("w1_done_c%0d", c), done, (c == 9));
      chk($sformatf("w1_reg_in_c%0d", c), reg_in, 16'hA5C3);
      @(posedge clkpos); #1;
    end
    chk("w1_shadow", shadow, 16'hA5C3);
    chk("w1_reg_in_held", reg_in, 16'hA5C3);

    // Forced mismatch: register returns 16'h00FE for 16'h00FF
    accept(16'h00FF, 16'h0001, 1'b1, 8'd1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clkpos);
      chk($sformatf("w2_done_c%0d", c), done, (c == 9));
      chk($sformatf("w2_mism_c%0d", c), mismatch, (c == 9));
      @(posedge clkpos); #1;
    end
    chk("w2_err_cnt", err_cnt, 1);

    // Busy rejection and back-to-back with wr_valid held high
    chk("b2b_ready_before", wr_ready, 1);
    flip = '0;
    wr_valid = 1'b1;
    wr_data  = 16'h1111;
    sb.push_back('{mism: 1'b0, shadow: 16'h1111, err: 8'd1});
    @(posedge clkpos); #1;
    wr_data = 16'h2222;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clkpos);
      chk($sformatf("b2b_ready_c%0d", c), wr_ready, (c == 9));
      chk($sformatf("b2b_done_c%0d", c), done, (c == 9));
      if (c < 9) chk($sformatf("b2b_shadow_c%0d", c), shadow, 16'h1111);
      if (c == 9) sb.push_back('{mism: 1'b0, shadow: 16'h2222, err: 8'd1});
      @(posedge clkpos); #1;
    end
    wr_valid = 1'b0;
    chk("b2b_second_accepted", wr_ready, 0);
    chk("b2b_reg_in", reg_in, 16'h2222);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clkpos);
      chk($sformatf("b2b2_done_c%0d", c), done, (c == 9));
      @(posedge clkpos); #1;
    end
    chk("b2b_shadow_final", shadow, 16'h2222);

    // Reset mid-CAPTURE
    accept(16'h3C3C, 16'h0000, 1'b0, 8'd1);
    repeat (3) begin @(posedge clkpos); #1; end
    #2;
    chk("mid_capture_rails", {Tclkpos, pclkpos, Fclkpos}, 3'b110);
    rstn = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_pos_rails", {Tclkpos, pclkpos, Fclkpos}, 3'b000);
    chk("mid_rst_neg_rails", {Tclkneg, pclkneg, Fclkneg}, 3'b111);
    chk("mid_rst_shadow", shadow, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    repeat (2) @(posedge clkpos);
    #1;
    rstn = 1'b1;
    repeat (12) begin
      @(negedge clkpos);
      chk("post_rst_no_done", done, 0);
    end
    chk("post_rst_shadow", shadow, 0);
    chk("post_rst_ready", wr_ready, 1);
    @(posedge clkpos); #1;

    // Saturation with ERR_W=2 and one-cycle phases: done in cycle 5
    for (int k = 0; k < 4; k++) begin
      accept2(16'h0F0F + 16'(k), 16'h8000, 1'b1, (k < 3) ? 8'(k + 1) : 8'd3);
      for (int c = 1; c <= 5; c++) begin
        @(negedge clkpos);
        chk($sformatf("sat%0d_done_c%0d", k, c), done2, (c == 5));
        @(posedge clkpos); #1;
      end
    end
    chk("sat_err_cnt_final", {30'd0, err_cnt2}, 3);

    chk("sb_drained", sb.size(), 0);
    chk("sb2_drained", sb2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
